// File: rtl/p1nnser_keeper_reg_if.sv
// ---------------------------------------------------------------------------
// p1nnser_keeper_reg_if
//
// Purpose: bundles the evaluate/clear controls, the lane gate inputs and the
// registered lane results of the p1nnser_keeper_reg block so they can travel
// as one port.
//
// Parameters:
//   W      number of lanes
//   N      series pull-down depth per lane
//   CNT_W  width of the contention event counter
//
// Signals:
//   EN        evaluate enable (master -> slave)
//   CLR       synchronous clear of sticky flags and counter (master -> slave)
//   A         per-lane pull-up gate, PMOS on when 0 (master -> slave)
//   B         pull-down stack gates, lane i uses B[i*N +: N] (master -> slave)
//   Z         registered lane outputs (slave -> master)
//   CONT      sticky per-lane contention flags (slave -> master)
//   LEAK      sticky per-lane leak flags (slave -> master)
//   CONT_CNT  saturating count of contention cycles (slave -> master)
// ---------------------------------------------------------------------------
interface p1nnser_keeper_reg_if #(
  parameter int W     = 4,
  parameter int N     = 2,
  parameter int CNT_W = 8
);

  logic               EN;
  logic               CLR;
  logic [W-1:0]       A;
  logic [N*W-1:0]     B;
  logic [W-1:0]       Z;
  logic [W-1:0]       CONT;
  logic [W-1:0]       LEAK;
  logic [CNT_W-1:0]   CONT_CNT;

  // The bench (or the surrounding logic) drives the gates and controls.
  modport master (
    output EN,
    output CLR,
    output A,
    output B,
    input  Z,
    input  CONT,
    input  LEAK,
    input  CONT_CNT
  );

  // The keeper register consumes the gates and produces the results.
  modport slave (
    input  EN,
    input  CLR,
    input  A,
    input  B,
    output Z,
    output CONT,
    output LEAK,
    output CONT_CNT
  );

endinterface

// File: rtl/p1nnser_keeper_reg.sv
// ---------------------------------------------------------------------------
// p1nnser_keeper_reg
//
// Purpose: clocked behavioural model of a multi-lane ratioed compound cell.
// Each lane has one PMOS pull-up (gate A[i]) against an N-deep series NMOS
// pull-down stack (gates B[i*N +: N]). The lane value is registered and held
// by a keeper; long floats decay to LEAK_V, and pull-up/pull-down fights are
// resolved according to MODE and recorded in sticky flags and a counter.
//
// Parameters:
//   W         number of independent lanes
//   N         series NMOS depth per lane (1..8)
//   MODE      contention resolution: 0 = hold previous Z, 1 = pull-down wins
//   RST_Z     reset value of every Z bit
//   HOLD_MAX  consecutive enabled float edges before leak (0 = no leak)
//   LEAK_V    value a floating lane decays to on leak
//   CNT_W     contention event counter width
//
// Ports:
//   CK                  rising-edge clock
//   R                   asynchronous active-high reset
//   VDD, VNW, VPW, VSS  supply/bulk pins, functionally unused
//   bus (slave)         EN, CLR, A, B in; Z, CONT, LEAK, CONT_CNT out
// ---------------------------------------------------------------------------
module p1nnser_keeper_reg #(
  parameter int   W        = 4,
  parameter int   N        = 2,
  parameter int   MODE     = 1,
  parameter logic RST_Z    = 1'b0,
  parameter int   HOLD_MAX = 15,
  parameter logic LEAK_V   = 1'b0,
  parameter int   CNT_W    = 8
) (
  input  logic                   CK,
  input  logic                   R,
  inout  wire                    VDD,
  inout  wire                    VNW,
  inout  wire                    VPW,
  inout  wire                    VSS,
  p1nnser_keeper_reg_if.slave    bus
);

  // Float counter only needs to reach HOLD_MAX; keep at least one bit so the
  // storage exists even when leak modelling is disabled.
  localparam int FW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [FW-1:0] HOLD_CAP  = FW'(HOLD_MAX);
  localparam logic [FW-1:0] HOLD_LAST = FW'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Supply pins exist only so the cell footprint matches the library view.
  logic unused_supply;
  assign unused_supply = ^{VDD, VNW, VPW, VSS};

  logic [W-1:0]          z_q;
  logic [W-1:0]          cont_q;
  logic [W-1:0]          leak_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [W-1:0][FW-1:0]  fcnt_q;

  logic [W-1:0]          pu;
  logic [W-1:0]          pd;
  logic [W-1:0]          z_nxt;
  logic [W-1:0][FW-1:0]  fcnt_nxt;
  logic [W-1:0]          cont_evt;
  logic [W-1:0]          leak_evt;
  logic                  any_cont;
  logic [W-1:0]          cont_nxt;
  logic [W-1:0]          leak_nxt;
  logic [CNT_W-1:0]      cnt_nxt;

  // The pull-up conducts when its gate is low; the series stack conducts
  // only when every gate in the lane's slice is high (N=1 degenerates to a
  // single transistor).
  always_comb begin
    pu = ~bus.A;
    pd = '0;
    for (int i = 0; i < W; i++) begin
      pd[i] = &bus.B[i*N +: N];
    end
  end

  // Per-lane next state. A float lane counts enabled float edges; the edge on
  // which the count reaches HOLD_MAX forces LEAK_V and raises the leak event,
  // after which the count parks at HOLD_MAX and Z stays at LEAK_V until the
  // lane is driven again.
  always_comb begin
    z_nxt    = z_q;
    fcnt_nxt = fcnt_q;
    cont_evt = '0;
    leak_evt = '0;
    for (int i = 0; i < W; i++) begin
      case ({pu[i], pd[i]})
        2'b10: begin
          z_nxt[i]    = 1'b1;
          fcnt_nxt[i] = '0;
        end
        2'b01: begin
          z_nxt[i]    = 1'b0;
          fcnt_nxt[i] = '0;
        end
        2'b11: begin
          if (MODE != 0) begin
            z_nxt[i] = 1'b0;
          end
          cont_evt[i] = 1'b1;
          fcnt_nxt[i] = '0;
        end
        default: begin
          if (HOLD_MAX > 0) begin
            if (fcnt_q[i] == HOLD_CAP) begin
              z_nxt[i] = LEAK_V;
            end else if (fcnt_q[i] == HOLD_LAST) begin
              fcnt_nxt[i] = HOLD_CAP;
              z_nxt[i]    = LEAK_V;
              leak_evt[i] = 1'b1;
            end else begin
              fcnt_nxt[i] = fcnt_q[i] + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Sticky flags and the contention counter. A clear wipes old history but
  // still records whatever happens on the clearing edge itself, so no event
  // is ever lost to a coincident clear.
  always_comb begin
    any_cont = |cont_evt;
    cont_nxt = cont_q | cont_evt;
    leak_nxt = leak_q | leak_evt;
    cnt_nxt  = cnt_q;
    if (bus.CLR) begin
      cont_nxt = cont_evt;
      leak_nxt = leak_evt;
      cnt_nxt  = any_cont ? CNT_W'(1) : '0;
    end else if (any_cont && (cnt_q != CNT_MAX)) begin
      cnt_nxt = cnt_q + 1'b1;
    end
  end

  // All state is frozen while EN is low, including the effect of CLR.
  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      z_q    <= {W{RST_Z}};
      cont_q <= '0;
      leak_q <= '0;
      cnt_q  <= '0;
      fcnt_q <= '0;
    end else if (bus.EN) begin
      z_q    <= z_nxt;
      cont_q <= cont_nxt;
      leak_q <= leak_nxt;
      cnt_q  <= cnt_nxt;
      fcnt_q <= fcnt_nxt;
    end
  end

  assign bus.Z        = z_q;
  assign bus.CONT     = cont_q;
  assign bus.LEAK     = leak_q;
  assign bus.CONT_CNT = cnt_q;

endmodule

// File: tb/tb_p1nnser_keeper_reg.sv
// ---------------------------------------------------------------------------
// tb_p1nnser_keeper_reg
//
// Purpose: exercises two configurations of p1nnser_keeper_reg side by side
// (default parameters, and a MODE=0 / N=3 / HOLD_MAX=3 / CNT_W=2 variant)
// against a lane-level reference model, with directed scenarios followed by
// randomized traffic and asynchronous reset pulses.
// ---------------------------------------------------------------------------
module tb_p1nnser_keeper_reg;

  logic CK = 1'b0;
  logic R  = 1'b0;
  always #5 CK = ~CK;

  logic        en  = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  a   = 4'hF;
  logic [7:0]  b_a = '0;
  logic [11:0] b_b = '0;

  wire vdd;
  wire vnw;
  wire vpw;
  wire vss;
  assign vdd = 1'b1;
  assign vnw = 1'b1;
  assign vpw = 1'b0;
  assign vss = 1'b0;

  p1nnser_keeper_reg_if #(.W(4), .N(2), .CNT_W(8)) bus_a ();
  p1nnser_keeper_reg_if #(.W(4), .N(3), .CNT_W(2)) bus_b ();

  assign bus_a.EN  = en;
  assign bus_a.CLR = clr;
  assign bus_a.A   = a;
  assign bus_a.B   = b_a;
  assign bus_b.EN  = en;
  assign bus_b.CLR = clr;
  assign bus_b.A   = a;
  assign bus_b.B   = b_b;

  p1nnser_keeper_reg #(
    .W(4), .N(2), .MODE(1), .RST_Z(1'b0), .HOLD_MAX(15), .LEAK_V(1'b0), .CNT_W(8)
  ) dut_a (
    .CK(CK), .R(R), .VDD(vdd), .VNW(vnw), .VPW(vpw), .VSS(vss), .bus(bus_a)
  );

  p1nnser_keeper_reg #(
    .W(4), .N(3), .MODE(0), .RST_Z(1'b1), .HOLD_MAX(3), .LEAK_V(1'b1), .CNT_W(2)
  ) dut_b (
    .CK(CK), .R(R), .VDD(vdd), .VNW(vnw), .VPW(vpw), .VSS(vss), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model configuration, one entry per DUT.
  int c_n[2]      = '{2, 3};
  int c_mode[2]   = '{1, 0};
  int c_rstz[2]   = '{0, 1};
  int c_hold[2]   = '{15, 3};
  int c_leakv[2]  = '{0, 1};
  int c_cntmax[2] = '{255, 3};

  // Reference model state: lane values, flags, event count and the number of
  // consecutive enabled float edges seen by each lane.
  logic [3:0] m_z[2];
  logic [3:0] m_cont[2];
  logic [3:0] m_leak[2];
  int         m_cnt[2];
  int         m_float[2][4];

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_z[k]    = (c_rstz[k] != 0) ? 4'hF : 4'h0;
      m_cont[k] = '0;
      m_leak[k] = '0;
      m_cnt[k]  = 0;
      for (int i = 0; i < 4; i++) m_float[k][i] = 0;
    end
  endtask

  task automatic model_edge(input int k, input logic [3:0] av,
                            input logic [11:0] bv, input logic env,
                            input logic clrv);
    logic [3:0] new_cont;
    logic [3:0] new_leak;
    bit pu;
    bit pd;
    if (!env) return;
    new_cont = '0;
    new_leak = '0;
    for (int i = 0; i < 4; i++) begin
      pu = !av[i];
      pd = 1'b1;
      for (int j = 0; j < c_n[k]; j++) pd = pd && bv[i*c_n[k] + j];
      if (pu && !pd) begin
        m_z[k][i] = 1'b1;
        m_float[k][i] = 0;
      end else if (!pu && pd) begin
        m_z[k][i] = 1'b0;
        m_float[k][i] = 0;
      end else if (pu && pd) begin
        if (c_mode[k] != 0) m_z[k][i] = 1'b0;
        new_cont[i] = 1'b1;
        m_float[k][i] = 0;
      end else if (c_hold[k] > 0 && m_float[k][i] < c_hold[k]) begin
        m_float[k][i]++;
        if (m_float[k][i] == c_hold[k]) begin
          m_z[k][i] = c_leakv[k][0];
          new_leak[i] = 1'b1;
        end
      end
    end
    if (clrv) begin
      m_cont[k] = new_cont;
      m_leak[k] = new_leak;
      m_cnt[k]  = (new_cont != 0) ? 1 : 0;
    end else begin
      m_cont[k] = m_cont[k] | new_cont;
      m_leak[k] = m_leak[k] | new_leak;
      if (new_cont != 0 && m_cnt[k] < c_cntmax[k]) m_cnt[k]++;
    end
  endtask

  task automatic check_all();
    check_output("a_z",    32'(bus_a.Z),        32'(m_z[0]));
    check_output("a_cont", 32'(bus_a.CONT),     32'(m_cont[0]));
    check_output("a_leak", 32'(bus_a.LEAK),     32'(m_leak[0]));
    check_output("a_cnt",  32'(bus_a.CONT_CNT), 32'(m_cnt[0]));
    check_output("b_z",    32'(bus_b.Z),        32'(m_z[1]));
    check_output("b_cont", 32'(bus_b.CONT),     32'(m_cont[1]));
    check_output("b_leak", 32'(bus_b.LEAK),     32'(m_leak[1]));
    check_output("b_cnt",  32'(bus_b.CONT_CNT), 32'(m_cnt[1]));
  endtask

  // Inputs change at the current time (away from the rising edge); the
  // outputs are sampled 1 time unit after the edge that consumes them.
  task automatic apply_stimulus(input logic [3:0] av, input logic [7:0] bav,
                                input logic [11:0] bbv, input logic env,
                                input logic clrv);
    a   = av;
    b_a = bav;
    b_b = bbv;
    en  = env;
    clr = clrv;
    @(posedge CK);
    model_edge(0, av, {4'b0, bav}, env, clrv);
    model_edge(1, av, bbv, env, clrv);
    #1;
    check_all();
    @(negedge CK);
  endtask

  // Drive every gate in a lane's stack to the same value from a lane mask.
  task automatic drive_mask(input logic [3:0] av, input logic [3:0] m,
                            input logic env, input logic clrv);
    logic [7:0]  ba;
    logic [11:0] bb;
    for (int i = 0; i < 4; i++) begin
      ba[i*2 +: 2] = {2{m[i]}};
      bb[i*3 +: 3] = {3{m[i]}};
    end
    apply_stimulus(av, ba, bb, env, clrv);
  endtask

  // Reset is raised between edges and checked before any edge can occur.
  task automatic apply_reset();
    @(negedge CK);
    #2 R = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge CK);
    R = 1'b0;
  endtask

  logic [3:0] snap_z;
  logic [3:0] snap_leak;

  initial begin
    apply_reset();
    check_output("rst_a_z",   32'(bus_a.Z), 32'h0);
    check_output("rst_a_cnt", 32'(bus_a.CONT_CNT), 32'h0);
    check_output("rst_b_z",   32'(bus_b.Z), 32'hF);

    // Basic drive: pull-down on every lane, then float lanes 1 and 3.
    drive_mask(4'b1010, 4'b1111, 1'b1, 1'b0);
    check_output("drive_z0", 32'(bus_a.Z), 32'h0);
    drive_mask(4'b1010, 4'b0000, 1'b1, 1'b0);
    check_output("drive_z5", 32'(bus_a.Z), 32'h5);

    // Leak on lane 0 after 15 float edges, then re-drive.
    drive_mask(4'b1110, 4'b0000, 1'b1, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      drive_mask(4'b1111, 4'b0000, 1'b1, 1'b0);
      check_output("leak_z0", 32'(bus_a.Z[0]), (k < 15) ? 32'd1 : 32'd0);
    end
    check_output("leak_flag0", 32'(bus_a.LEAK[0]), 32'd1);
    drive_mask(4'b1110, 4'b0000, 1'b1, 1'b0);
    check_output("redrive_z0", 32'(bus_a.Z[0]), 32'd1);
    check_output("redrive_leak0", 32'(bus_a.LEAK[0]), 32'd1);

    // Contention on lane 2 for three cycles, then saturate the narrow counter.
    apply_reset();
    for (int k = 0; k < 3; k++) drive_mask(4'b1011, 4'b0100, 1'b1, 1'b0);
    check_output("cont_z2",   32'(bus_a.Z[2]), 32'd0);
    check_output("cont_flag", 32'(bus_a.CONT), 32'h4);
    check_output("cont_cnt",  32'(bus_a.CONT_CNT), 32'd3);
    check_output("hold_z2",   32'(bus_b.Z[2]), 32'd1);
    for (int k = 0; k < 2; k++) drive_mask(4'b1011, 4'b0100, 1'b1, 1'b0);
    check_output("sat_cnt_b", 32'(bus_b.CONT_CNT), 32'd3);
    check_output("cnt_a5",    32'(bus_a.CONT_CNT), 32'd5);
    drive_mask(4'b1101, 4'b0010, 1'b1, 1'b1);
    check_output("clr_cnt_b",  32'(bus_b.CONT_CNT), 32'd1);
    check_output("clr_cont_b", 32'(bus_b.CONT), 32'h2);
    check_output("clr_cnt_a",  32'(bus_a.CONT_CNT), 32'd1);

    // Freeze mid-float: EN low for 20 cycles must not advance anything.
    apply_reset();
    drive_mask(4'b1110, 4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) drive_mask(4'b1111, 4'b0000, 1'b1, 1'b0);
    snap_z    = bus_a.Z;
    snap_leak = bus_a.LEAK;
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(4'($urandom), 8'($urandom), 12'($urandom), 1'b0,
                     1'($urandom));
    end
    check_output("frz_z",    32'(bus_a.Z), 32'(snap_z));
    check_output("frz_leak", 32'(bus_a.LEAK), 32'(snap_leak));
    for (int k = 0; k < 9; k++) drive_mask(4'b1111, 4'b0000, 1'b1, 1'b0);
    check_output("frz_z0_14", 32'(bus_a.Z[0]), 32'd1);
    drive_mask(4'b1111, 4'b0000, 1'b1, 1'b0);
    check_output("frz_z0_15", 32'(bus_a.Z[0]), 32'd0);
    check_output("frz_leak0", 32'(bus_a.LEAK[0]), 32'd1);

    // Randomized traffic with biased gates so floats, drives and fights all
    // occur, plus occasional asynchronous resets.
    for (int blk = 0; blk < 12; blk++) begin
      int b_bias;
      int a_bias;
      b_bias = $urandom_range(0, 2);
      a_bias = $urandom_range(0, 2);
      for (int k = 0; k < 40; k++) begin
        logic [3:0]  ra;
        logic [11:0] rb;
        if ($urandom_range(0, 59) == 0) begin
          apply_reset();
        end else begin
          for (int i = 0; i < 4; i++) ra[i] = ($urandom_range(0, 3) < a_bias + 1);
          for (int i = 0; i < 12; i++) rb[i] = ($urandom_range(0, 3) < b_bias + 1);
          apply_stimulus(ra, rb[7:0], rb, ($urandom_range(0, 7) != 0),
                         ($urandom_range(0, 15) == 0));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
